// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round count, S-box and state-permutation helpers.
// Byte 0 of a 128-bit state is bits [127:120]; bytes are ordered column-major.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_state_e;

  // Entry x of the S-box sits at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[(11'd2047 - {x, 3'b000}) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of the state rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = s;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/mix_columns.sv
// Combinational AES MixColumns over the four 32-bit state columns.
module mix_columns (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  import aes_pkg::*;

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign data_o[127-32*c -: 32] = mix_col(data_i[127-32*c -: 32]);
  end

endmodule

// File: rtl/subbyte.sv
// 128-bit SubBytes: the AES S-box applied to each of the sixteen state bytes.
module subbyte (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  import aes_pkg::*;

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_o[8*i +: 8] = sbox(data_i[8*i +: 8]);
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption: one round per clock, round keys supplied by an external
// key-schedule stage that follows round_nr_o.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] plaintext_i,
  input  logic [127:0] key_i,
  output logic [127:0] master_key_o,
  output logic [3:0]   round_nr_o,
  input  logic [127:0] round_key_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] ciphertext_o,
  output logic         busy_o
);
  import aes_pkg::*;

  aes_state_e   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] sub_bytes, shifted, mixed;

  assign master_key_o = key_i;

  subbyte u_subbyte (
    .data_i (state_q),
    .data_o (sub_bytes)
  );

  assign shifted = shift_rows(sub_bytes);

  mix_columns u_mix_columns (
    .data_i (shifted),
    .data_o (mixed)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Rounds run back to back with no stall: the key schedule depends on it.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = plaintext_i ^ round_key_i;
          cnt_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (cnt_q == 4'(NUM_ROUNDS)) begin
          state_d = shifted ^ round_key_i;
          cnt_d   = '0;
          fsm_d   = DONE;
        end else begin
          state_d = mixed ^ round_key_i;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready_i) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    busy_o       = 1'b1;
    round_nr_o   = '0;
    ciphertext_o = '0;
    case (fsm_q)
      IDLE: begin
        in_ready_o = rst_ni;
        busy_o     = 1'b0;
      end
      ROUND: round_nr_o = cnt_q;
      DONE: begin
        out_valid_o  = 1'b1;
        ciphertext_o = state_q;
      end
      default: busy_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl with a byte-level AES-128 reference and a key-schedule model.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rstN;
  logic         inValid;
  logic         inReady;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] masterKey;
  logic [3:0]   roundNr;
  logic [127:0] roundKey;
  logic         outValid;
  logic         outReady = 1'b1;
  logic [127:0] ciphertext;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int readyMode = 0;

  logic [127:0] expQ[$];
  logic [127:0] rkArr[0:10];
  logic [7:0]   sboxT[0:255];

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Key-schedule stand-in: round 0 passes the live key, later rounds come from the accepted key.
  assign roundKey = (roundNr == 4'd0) ? masterKey :
                    (roundNr <= 4'd10) ? rkArr[roundNr] : '0;

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       outReady = 1'b1;
      1:       outReady = 1'b0;
      default: outReady = 1'($urandom_range(0, 1));
    endcase
  end

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .in_valid_i   (inValid),
    .in_ready_o   (inReady),
    .plaintext_i  (plaintext),
    .key_i        (key),
    .master_key_o (masterKey),
    .round_nr_o   (roundNr),
    .round_key_i  (roundKey),
    .out_valid_o  (outValid),
    .out_ready_i  (outReady),
    .ciphertext_o (ciphertext),
    .busy_o       (busy)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] keyRound(input logic [127:0] k, input int r);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sboxT[t[31:24]], sboxT[t[23:16]], sboxT[t[15:8]], sboxT[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aesRef(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   st[16];
    logic [7:0]   tmp[16];
    logic [127:0] rk;
    logic [127:0] res;
    rk = keyRound(k, 0);
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) st[i] = sboxT[st[i]];
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          tmp[row+4*col] = st[row+4*((col+row)%4)];
      if (rnd < 10) begin
        for (int col = 0; col < 4; col++)
          for (int row = 0; row < 4; row++)
            st[row+4*col] = gmul(tmp[row+4*col], 8'h02) ^ gmul(tmp[(row+1)%4+4*col], 8'h03)
                          ^ tmp[(row+2)%4+4*col] ^ tmp[(row+3)%4+4*col];
      end else begin
        st = tmp;
      end
      rk = keyRound(k, rnd);
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // Monitor: follows the expected round sequence after each accept and pops the scoreboard on output.
  bit           active = 1'b0;
  bit           popped = 1'b0;
  int           since = 0;
  int           expRound;
  logic [127:0] curExp = '0;

  always @(negedge clk) begin
    if (!rstN) begin
      active = 1'b0;
      popped = 1'b0;
      checkOutput("reset_in_ready", 128'(inReady), 128'(0));
      checkOutput("reset_out_valid", 128'(outValid), 128'(0));
      checkOutput("reset_busy", 128'(busy), 128'(0));
      checkOutput("reset_round_nr", 128'(roundNr), 128'(0));
      checkOutput("reset_ciphertext", ciphertext, 128'(0));
    end else begin
      if (active) since++;
      expRound = (active && since >= 1 && since <= 10) ? since : 0;
      checkOutput("round_nr", 128'(roundNr), 128'(expRound));
      checkOutput("busy", 128'(busy), 128'(active));
      checkOutput("out_valid", 128'(outValid), 128'(active && since >= 11));
      checkOutput("in_ready", 128'(inReady), 128'(!active));
      if (outValid) begin
        if (!popped) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got %h, expected no output", ciphertext);
          end else begin
            curExp = expQ.pop_front();
          end
          popped = 1'b1;
        end
        checkOutput("ciphertext", ciphertext, curExp);
        if (outReady) begin
          active = 1'b0;
          popped = 1'b0;
        end
      end else begin
        checkOutput("ciphertext_idle_zero", ciphertext, 128'(0));
      end
      if (inValid && inReady) begin
        active = 1'b1;
        since  = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k,
                               input logic [127:0] exp, output int accCycle);
    @(posedge clk);
    #1;
    inValid   = 1'b1;
    plaintext = pt;
    key       = k;
    accCycle  = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inReady) begin
        for (int r = 0; r <= 10; r++) rkArr[r] = keyRound(k, r);
        expQ.push_back(exp);
        accCycle = cycle;
        break;
      end
    end
    if (accCycle < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 40 cycles, expected 1");
    end
    @(posedge clk);
    #1;
    inValid   = 1'b0;
    plaintext = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic waitDrain();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy && expQ.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got busy=%0b pending=%0d, expected idle", busy, expQ.size());
    end
  endtask

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    int           accA, accB;
    bit           seen;
    logic [127:0] rp, rk;
    logic [7:0]   inv;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxT[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int r = 0; r <= 10; r++) rkArr[r] = '0;

    rstN      = 1'b0;
    inValid   = 1'b0;
    plaintext = '0;
    key       = '0;
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    $display("[TB] FIPS-197 vector with in_valid held and plaintext changing during the rounds");
    applyStimulus(PT1, K1, CT1, accA);
    repeat (8) begin
      @(posedge clk);
      #1;
      inValid   = 1'b1;
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk);
    #1 inValid = 1'b0;
    waitDrain();

    $display("[TB] Appendix-B vector with out_ready held low for 5 cycles");
    readyMode = 1;
    applyStimulus(PT2, K2, CT2, accA);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (outValid) seen = 1'b1;
    end
    checkOutput("stall_out_valid_seen", 128'(seen), 128'(1));
    repeat (5) @(negedge clk);
    readyMode = 0;
    waitDrain();

    $display("[TB] reset pulse in round 5, then a fresh block");
    applyStimulus(PT1, K1, CT1, accA);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (roundNr == 4'd5) seen = 1'b1;
    end
    checkOutput("reached_round5", 128'(seen), 128'(1));
    #2 rstN = 1'b0;
    expQ.delete();
    #1;
    checkOutput("abort_busy", 128'(busy), 128'(0));
    checkOutput("abort_out_valid", 128'(outValid), 128'(0));
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    applyStimulus(PT2, K2, CT2, accA);
    waitDrain();

    $display("[TB] back-to-back offers");
    applyStimulus(PT1, K1, CT1, accA);
    applyStimulus(PT2, K2, CT2, accB);
    checkOutput("b2b_accept_spacing", 128'(accB - accA), 128'(12));
    waitDrain();

    $display("[TB] random blocks with random out_ready");
    readyMode = 2;
    for (int n = 0; n < 20; n++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(rp, rk, aesRef(rp, rk), accA);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    readyMode = 0;
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected end of stimulus");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, AES-128 round count; only the value 10 is supported.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous and active-low.
REQ-004 in_valid_i  in  1  plaintext/key offer.
REQ-005 in_ready_o  out  1  block can accept an offer.
REQ-006 plaintext_i  in  128  plaintext block; byte 0 = bits [127:120], column-major AES state.
REQ-007 key_i  in  128  cipher key, same byte order.
REQ-008 master_key_o  out  128  key to the key-schedule stage; equals key_i combinationally.
REQ-009 round_nr_o  out  4  round index driven to the key-schedule stage.
REQ-010 round_key_i  in  128  round key returned combinationally by the key-schedule stage for the current round_nr_o.
REQ-011 out_valid_o  out  1  ciphertext available.
REQ-012 out_ready_i  in  1  consumer accepts ciphertext.
REQ-013 ciphertext_o  out  128  encrypted block.
REQ-014 busy_o  out  1  high in every state other than IDLE.

Function
REQ-015 FSM states: IDLE, ROUND, DONE.
REQ-016 IDLE behaviour: in_ready_o=1, round_nr_o=0, out_valid_o=0.
REQ-017 IDLE transition: on in_valid_i&in_ready_o, state_q <= plaintext_i ^ round_key_i (round-0 key = key_i), round counter <= 1, go to ROUND.
REQ-018 ROUND, counter r in 1..9: round_nr_o=r; state_q <= MixColumns(ShiftRows(SubBytes(state_q))) ^ round_key_i; r increments.
REQ-019 ROUND, r=10: round_nr_o=10; state_q <= ShiftRows(SubBytes(state_q)) ^ round_key_i (MixColumns omitted); go to DONE.
REQ-020 round_nr_o steps 0,1,...,10 on consecutive cycles with no gaps or stalls, because the key-schedule stage derives each key from the previous cycle's key.
REQ-021 DONE behaviour: out_valid_o=1, ciphertext_o=state_q, round_nr_o=0, in_ready_o=0.
REQ-022 DONE transition: go to IDLE on out_ready_i=1; otherwise hold with ciphertext_o stable.
REQ-023 Latency: accept in cycle T -> out_valid_o first high in cycle T+11; with out_ready_i tied high, one block per 12 cycles.
REQ-024 No new offer is accepted in the DONE handshake cycle; in_ready_o rises the following cycle.
REQ-025 in_valid_i, plaintext_i and key_i are ignored outside IDLE; key_i is sampled only via round_key_i in the accept cycle.
REQ-026 SubBytes uses the standard AES S-box; MixColumns uses GF(2^8) with polynomial 0x11B; xtime = shift-left with conditional ^0x1B.
REQ-027 ciphertext_o reads 0 whenever out_valid_o=0.

Reset
REQ-028 Assertion of rst_ni=0, including mid-operation, returns the FSM to IDLE immediately and aborts the block in flight with no output.
REQ-029 On reset, state_q=0, counter=0, out_valid_o=0, ciphertext_o=0, busy_o=0, round_nr_o=0.
REQ-030 in_ready_o is 0 while rst_ni=0 and is 1 from the first cycle after deassertion.

Structure
REQ-031 A shared package aes_pkg holds: the FSM state enum, the NUM_ROUNDS constant, the S-box table/function, the xtime function and the shift_rows function.
REQ-032 The block instantiates the existing 128-bit subbyte module for SubBytes.
REQ-033 MixColumns lives in one new combinational sub-module, mix_columns (128-bit in, 128-bit out).
REQ-034 The key-schedule stage is instantiated beside this block at the top level, not inside it.

Verification
REQ-035 Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a at T+11; round_nr_o observed as 0..10 on consecutive cycles.
REQ-036 Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32.
REQ-037 out_ready_i held low for 5 cycles after out_valid_o -> ciphertext_o stable and in_ready_o=0 throughout; IDLE one cycle after out_ready_i=1.
REQ-038 in_valid_i held high with a changing plaintext_i during ROUND -> no effect on the result of REQ-035.
REQ-039 rst_ni pulsed low at round 5 -> immediately out_valid_o=0, busy_o=0; a following REQ-036 run yields the correct ciphertext.
REQ-040 Back-to-back offers with out_ready_i=1 -> both ciphertexts correct, accepts 12 cycles apart.
